// File: rtl/pll_clken_gen.sv
// pll_clken_gen: multi-channel fractional clock-enable generator on the PLL
// output clock. Each channel emits single-cycle strobes at refclk*num/den.
// All strobes are gated on a synchronised, qualified PLL lock.
//
// Ports:
//   refclk      system clock (PLL outclk_0)
//   rst_n       asynchronous active-low reset
//   pll_locked  raw PLL lock, asynchronous to refclk
//   cfg_we      config write strobe (one cycle)
//   cfg_ch      channel index for the write (>= NUM_CH is ignored)
//   cfg_num     numerator (increment)
//   cfg_den     denominator (modulus)
//   clken       per-channel enable strobes, registered
//   ready       lock held for LOCK_DLY cycles; enables active
//   lost_lock   sticky: lock dropped after ready was high
//
// CH_W must satisfy 2**CH_W >= NUM_CH.
module pll_clken_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned LOCK_DLY = 1024,
  parameter int unsigned CH_W     = 2
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] clken,
  output logic              ready,
  output logic              lost_lock
);

  localparam int unsigned CNT_W = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_READY = 2'd2
  } lock_state_e;

  lock_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ready_nxt, lost_nxt;
  logic             sync1, lk_s;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
    end
  end

  // Lock qualification state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      ready     <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready     <= ready_nxt;
      lost_lock <= lost_nxt;
    end
  end

  // Next-state logic. The cycle that leaves WAIT is the first counted
  // locked cycle, so ready rises after exactly LOCK_DLY cycles of lk_s=1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    lost_nxt  = lost_lock;
    case (state)
      ST_WAIT: begin
        cnt_nxt = '0;
        if (lk_s) begin
          if (LOCK_DLY == 1) begin
            state_nxt = ST_READY;
          end else begin
            state_nxt = ST_COUNT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_COUNT: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_DLY - 1)) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (!lk_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
    endcase
    ready_nxt = (state_nxt == ST_READY);
    lost_nxt  = lost_lock | ((state == ST_READY) && (state_nxt != ST_READY));
  end

  logic [ACC_W-1:0] num_q   [NUM_CH];
  logic [ACC_W-1:0] den_q   [NUM_CH];
  logic [ACC_W-1:0] acc_q   [NUM_CH];
  logic [ACC_W-1:0] num_eff [NUM_CH];
  logic [ACC_W:0]   sum     [NUM_CH];
  logic [NUM_CH-1:0] hit, ch_en;
  logic              advance;

  // Accumulate only while ready stays high; the falling cycle already clears.
  assign advance = ready & ready_nxt;

  // Per-channel accumulator arithmetic; num is clamped to den so acc < den.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      num_eff[i] = (num_q[i] > den_q[i]) ? den_q[i] : num_q[i];
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, num_eff[i]};
      hit[i]     = (sum[i] >= {1'b0, den_q[i]});
      ch_en[i]   = (num_q[i] != '0) && (den_q[i] != '0);
    end
  end

  // Config storage, accumulators and strobes. A write restarts its channel.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        num_q[i] <= '0;
        den_q[i] <= '0;
        acc_q[i] <= '0;
      end
      clken <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          num_q[i] <= cfg_num;
          den_q[i] <= cfg_den;
          acc_q[i] <= '0;
          clken[i] <= 1'b0;
        end else if (!advance || !ch_en[i]) begin
          acc_q[i] <= '0;
          clken[i] <= 1'b0;
        end else if (hit[i]) begin
          acc_q[i] <= ACC_W'(sum[i] - {1'b0, den_q[i]});
          clken[i] <= 1'b1;
        end else begin
          acc_q[i] <= ACC_W'(sum[i]);
          clken[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed testbench for pll_clken_gen (NUM_CH=4, LOCK_DLY=16, CH_W=3 so an
// out-of-range channel index is representable).
module tb_pll_clken_gen;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned ACC_W    = 16;
  localparam int unsigned LOCK_DLY = 16;
  localparam int unsigned CH_W     = 3;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic              pll_locked;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic [NUM_CH-1:0] clken;
  logic              ready;
  logic              lost_lock;

  int n_tests = 0;
  int n_fail  = 0;
  int now     = 0;

  // Reference model: ratio and restart point of each channel.
  logic m_run = 1'b0;
  int   m_num   [NUM_CH];
  int   m_den   [NUM_CH];
  int   m_start [NUM_CH];

  always #5 refclk = ~refclk;

  pll_clken_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .LOCK_DLY(LOCK_DLY),
    .CH_W    (CH_W)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .clken     (clken),
    .ready     (ready),
    .lost_lock (lost_lock)
  );

  // Closed form: channel restarted at tick s pulses at tick s+t when
  // floor(n*t/d) steps up.
  function automatic logic [NUM_CH-1:0] exp_clken();
    logic [NUM_CH-1:0] v;
    longint n, d, tt;
    v = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      n  = longint'(m_num[i]);
      d  = longint'(m_den[i]);
      tt = longint'(now - m_start[i]);
      if (m_run && n != 0 && d != 0 && tt > 0) begin
        if (n > d) n = d;
        v[i] = ((n * tt) / d) != ((n * (tt - 1)) / d);
      end
    end
    return v;
  endfunction

  // Advance one edge and settle; inputs and samples sit 1 ns after posedge.
  task automatic tick();
    @(posedge refclk);
    #1;
    now = now + 1;
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input int n, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_num = ACC_W'(n);
    cfg_den = ACC_W'(d);
    tick();
    cfg_we  = 1'b0;
    if (int'(ch) < int'(NUM_CH)) begin
      m_num[ch]   = n;
      m_den[ch]   = d;
      m_start[ch] = now;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_num = '0; cfg_den = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      m_num[i] = 0; m_den[i] = 0; m_start[i] = 0;
    end
    repeat (3) tick();
    n_tests++;
    if (clken !== 4'b0000) begin
      n_fail++; $display("FAIL reset_clken got=%b exp=0000", clken);
    end
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=0", ready);
    end
    n_tests++;
    if (lost_lock !== 1'b0) begin
      n_fail++; $display("FAIL reset_lost_lock got=%b exp=0", lost_lock);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Configure while unlocked, then lock: ready exactly 18 edges later.
  task automatic test_lock();
    wr(3'd0, 1, 48);
    wr(3'd1, 3, 8);
    wr(3'd2, 5, 5);
    wr(3'd3, 0, 7);
    n_tests++;
    if (clken !== 4'b0000 || ready !== 1'b0) begin
      n_fail++; $display("FAIL cfg_unlocked clken=%b ready=%b exp 0000/0", clken, ready);
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 18) begin
        m_run = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) m_start[i] = now;
      end
      n_tests++;
      if (ready !== (k == 18) || clken !== 4'b0000) begin
        n_fail++;
        $display("FAIL lock_delay k=%0d ready=%b exp=%b clken=%b exp=0000",
                 k, ready, (k == 18), clken);
      end
    end
  endtask

  // 1/48, 3/8, 5/5 and disabled ch3 over 800 cycles.
  task automatic test_ratios();
    int c0, c1, c2;
    logic [NUM_CH-1:0] e;
    c0 = 0; c1 = 0; c2 = 0;
    for (int t = 1; t <= 800; t++) begin
      tick();
      e = exp_clken();
      n_tests++;
      if (clken !== e || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ratios t=%0d clken=%b exp=%b ready=%b", t, clken, e, ready);
      end
      c0 += int'(clken[0]); c1 += int'(clken[1]); c2 += int'(clken[2]);
    end
    n_tests++;
    if (c0 != 16) begin n_fail++; $display("FAIL ch0_count got=%0d exp=16", c0); end
    n_tests++;
    if (c1 != 300) begin n_fail++; $display("FAIL ch1_count got=%0d exp=300", c1); end
    n_tests++;
    if (c2 != 800) begin n_fail++; $display("FAIL ch2_count got=%0d exp=800", c2); end
  endtask

  // One-cycle lock drop: ready falls 3 edges later, returns 16 after lk_s.
  task automatic test_lock_loss();
    logic [NUM_CH-1:0] e;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      e = exp_clken();
      n_tests++;
      if (ready !== 1'b1 || clken !== e || lost_lock !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_pre k=%0d ready=%b clken=%b exp=%b lost=%b", k, ready, clken, e, lost_lock);
      end
      tick();
    end
    m_run = 1'b0;
    n_tests++;
    if (ready !== 1'b0 || clken !== 4'b0000 || lost_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_fall ready=%b exp=0 clken=%b exp=0000 lost=%b exp=1", ready, clken, lost_lock);
    end
    wr(3'd3, 3, 0);
    n_tests++;
    if (ready !== 1'b0 || clken !== 4'b0000) begin
      n_fail++; $display("FAIL drop_write ready=%b clken=%b exp 0/0000", ready, clken);
    end
    for (int k = 5; k <= 19; k++) begin
      tick();
      if (k == 19) begin
        m_run = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) m_start[i] = now;
      end
      n_tests++;
      if (ready !== (k == 19) || clken !== 4'b0000 || lost_lock !== 1'b1) begin
        n_fail++;
        $display("FAIL relock k=%0d ready=%b exp=%b clken=%b lost=%b", k, ready, (k == 19), clken, lost_lock);
      end
    end
    for (int t = 1; t <= 100; t++) begin
      tick();
      e = exp_clken();
      n_tests++;
      if (clken !== e || ready !== 1'b1 || lost_lock !== 1'b1) begin
        n_fail++;
        $display("FAIL restart t=%0d clken=%b exp=%b ready=%b lost=%b", t, clken, e, ready, lost_lock);
      end
    end
  endtask

  // Mid-stream reconfig of ch0 and ch2, plus a write to channel 5.
  task automatic test_reconfig();
    logic [NUM_CH-1:0] e;
    for (int t = 1; t <= 13; t++) tick();
    wr(3'd0, 1, 6);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      e = exp_clken();
      n_tests++;
      if (clken[0] !== (k == 6) || clken !== e) begin
        n_fail++;
        $display("FAIL ch0_reconfig k=%0d clken=%b exp=%b ch0_exp=%b", k, clken, e, (k == 6));
      end
    end
    wr(3'd2, 9, 4);
    e = exp_clken();
    n_tests++;
    if (clken[2] !== 1'b0 || clken !== e) begin
      n_fail++; $display("FAIL ch2_write clken=%b exp=%b", clken, e);
    end
    wr(3'd5, 1, 2);
    e = exp_clken();
    n_tests++;
    if (clken !== e) begin
      n_fail++; $display("FAIL bad_ch_write clken=%b exp=%b", clken, e);
    end
    for (int t = 1; t <= 200; t++) begin
      tick();
      e = exp_clken();
      n_tests++;
      if (clken !== e || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL after_reconfig t=%0d clken=%b exp=%b ready=%b", t, clken, e, ready);
      end
    end
    n_tests++;
    if (lost_lock !== 1'b1) begin
      n_fail++; $display("FAIL lost_lock_sticky got=%b exp=1", lost_lock);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_ratios();
    test_lock_loss();
    test_reconfig();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
